// File: rtl/regfile_writeback_pkg.sv
// Shared types for the register-file write-back queue.
// Optional forwarding is enabled by defining WB_BYPASS_EN.
package regfile_writeback_pkg;

  typedef logic [4:0]  tag;
  typedef logic [31:0] word;

  typedef struct packed {
    tag  rd;
    word value;
  } wb_entry;

  localparam int wb_depth_default = 4;

endpackage

// File: rtl/regfile_writeback_wb_match.sv
// Per-read-port lookup of queued writes: hit, and with WB_BYPASS_EN
// the value of the youngest matching entry.
module wb_match
  import regfile_writeback_pkg::*;
#(
  parameter int DEPTH = wb_depth_default
) (
  input  tag [DEPTH-1:0]         tags,
  input  logic [DEPTH-1:0]       valid,
`ifdef WB_BYPASS_EN
  input  word [DEPTH-1:0]        values,
  input  logic [$clog2(DEPTH)-1:0] head,
  output word                    value,
`endif
  input  tag                     query,
  output logic                   hit
);

  localparam int AW = $clog2(DEPTH);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && tags[i] == query && query != '0)
        hit = 1'b1;
    end
  end

`ifdef WB_BYPASS_EN
  logic [AW-1:0] idx;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    value = '0;
    idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + k[AW-1:0];
      if (valid[idx] && tags[idx] == query && query != '0)
        value = values[idx];
    end
  end
`endif

endmodule

// File: rtl/regfile_writeback.sv
// In-order write-back queue with pending-write scoreboard.
// Define WB_BYPASS_EN to add the rsN_fwd_value forwarding ports.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int DEPTH = wb_depth_default
) (
  input  logic clock,
  input  logic reset,
  input  logic load_valid,
  input  tag   load_rd,
  input  word  load_value,
  input  logic alu_valid,
  input  tag   alu_rd,
  input  word  alu_value,
  output logic ready,
  output logic overflow,
  output logic write_to_rd,
  output tag   rd,
  output word  rd_value,
  input  tag   rs1,
  input  tag   rs2,
  output logic rs1_pending,
  output logic rs2_pending
`ifdef WB_BYPASS_EN
  ,
  output word  rs1_fwd_value,
  output word  rs2_fwd_value
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH - 2);

  wb_entry [DEPTH-1:0] mem;
  tag [DEPTH-1:0]      tags;
  logic [DEPTH-1:0]    valid;
  logic [AW-1:0]       head;
  logic [AW-1:0]       tail;
  logic [AW-1:0]       alu_slot;
  logic [AW:0]         count;
  logic [AW:0]         n_push;
  logic                ld_en;
  logic                al_en;
  logic                push;
  logic                deq;

  assign ready = count <= LIMIT;
  assign ld_en = load_valid && load_rd != '0;
  assign al_en = alu_valid && alu_rd != '0;
  assign push  = (ld_en || al_en) && ready;
  assign deq   = count != '0;

  assign n_push = push
    ? (AW+1)'(ld_en) + (AW+1)'(al_en)
    : '0;

  // Load is older, so it claims the first free slot.
  assign alu_slot = tail + AW'(ld_en);

  assign write_to_rd = deq;
  assign rd          = deq ? mem[head].rd : '0;
  assign rd_value    = deq ? mem[head].value : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        tail <= tail + n_push[AW-1:0];
      if (deq)
        head <= head + AW'(1);
      if ((ld_en || al_en) && !ready)
        overflow <= 1'b1;
      count <= count + n_push - (AW+1)'(deq);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push && ld_en)
      mem[tail] <= '{rd: load_rd, value: load_value};
    if (!reset && push && al_en)
      mem[alu_slot] <= '{rd: alu_rd, value: alu_value};
  end

`ifdef WB_BYPASS_EN
  word [DEPTH-1:0] values;
`endif

  for (genvar g = 0; g < DEPTH; g++) begin : g_split
    assign tags[g]  = mem[g].rd;
    assign valid[g] = {1'b0, AW'(g) - head} < count;
`ifdef WB_BYPASS_EN
    assign values[g] = mem[g].value;
`endif
  end

  wb_match #(.DEPTH(DEPTH)) u_match1 (
    .tags  (tags),
    .valid (valid),
`ifdef WB_BYPASS_EN
    .values(values),
    .head  (head),
    .value (rs1_fwd_value),
`endif
    .query (rs1),
    .hit   (rs1_pending)
  );

  wb_match #(.DEPTH(DEPTH)) u_match2 (
    .tags  (tags),
    .valid (valid),
`ifdef WB_BYPASS_EN
    .values(values),
    .head  (head),
    .value (rs2_fwd_value),
`endif
    .query (rs2),
    .hit   (rs2_pending)
  );

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed literals plus randomized
// traffic against a queue-based model.
module tb_regfile_writeback;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [4:0]  load_rd;
  logic [31:0] load_value;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_value;
  logic        ready;
  logic        overflow;
  logic        write_to_rd;
  logic [4:0]  rd;
  logic [31:0] rd_value;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_pending;
  logic        rs2_pending;
`ifdef WB_BYPASS_EN
  logic [31:0] rs1_fwd_value;
  logic [31:0] rs2_fwd_value;
`endif

  regfile_writeback #(.DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_rd      (load_rd),
    .load_value   (load_value),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_value    (alu_value),
    .ready        (ready),
    .overflow     (overflow),
    .write_to_rd  (write_to_rd),
    .rd           (rd),
    .rd_value     (rd_value),
    .rs1          (rs1),
    .rs2          (rs2),
    .rs1_pending  (rs1_pending),
    .rs2_pending  (rs2_pending)
`ifdef WB_BYPASS_EN
    ,
    .rs1_fwd_value(rs1_fwd_value),
    .rs2_fwd_value(rs2_fwd_value)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] value;
  } ent_t;

  ent_t q[$];
  bit   m_ovf = 1'b0;
  bit   m_rdy;
  bit   m_att;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_pend(logic [4:0] rs);
    if (rs == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i].rd == rs) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_fwd(logic [4:0] rs);
    logic [31:0] v;
    v = '0;
    if (rs == 5'd0) return v;
    foreach (q[i]) if (q[i].rd == rs) v = q[i].value;
    return v;
  endfunction

  // Reference model: a plain in-order list of pending writes.
  always @(posedge clock) begin
    if (reset) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      m_rdy = (DEPTH - q.size()) >= 2;
      m_att = (load_valid && load_rd != 0) || (alu_valid && alu_rd != 0);
      if (q.size() > 0) void'(q.pop_front());
      if (m_att && !m_rdy) begin
        m_ovf = 1'b1;
      end else begin
        if (load_valid && load_rd != 0)
          q.push_back('{rd: load_rd, value: load_value});
        if (alu_valid && alu_rd != 0)
          q.push_back('{rd: alu_rd, value: alu_value});
      end
    end
  end

  always @(negedge clock) begin
    if (checking) begin
      chk("m_write", 32'(write_to_rd), 32'(q.size() > 0));
      chk("m_rd", 32'(rd), (q.size() > 0) ? 32'(q[0].rd) : 32'd0);
      chk("m_rd_value", rd_value, (q.size() > 0) ? q[0].value : 32'd0);
      chk("m_ready", 32'(ready), 32'((DEPTH - q.size()) >= 2));
      chk("m_overflow", 32'(overflow), 32'(m_ovf));
      chk("m_rs1_pending", 32'(rs1_pending), 32'(m_pend(rs1)));
      chk("m_rs2_pending", 32'(rs2_pending), 32'(m_pend(rs2)));
`ifdef WB_BYPASS_EN
      chk("m_rs1_fwd", rs1_fwd_value, m_fwd(rs1));
      chk("m_rs2_fwd", rs2_fwd_value, m_fwd(rs2));
`endif
    end
  end

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drive(bit lv, logic [4:0] lrd, logic [31:0] lval,
                       bit av, logic [4:0] ard, logic [31:0] aval);
    load_valid = lv;
    load_rd    = lrd;
    load_value = lval;
    alu_valid  = av;
    alu_rd     = ard;
    alu_value  = aval;
    @(posedge clock);
    #1;
    load_valid = 1'b0;
    alu_valid  = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    load_valid = 1'b0;
    load_rd    = '0;
    load_value = '0;
    alu_valid  = 1'b0;
    alu_rd     = '0;
    alu_value  = '0;
    rs1        = '0;
    rs2        = '0;
    idle(2);
    reset    = 1'b0;
    checking = 1'b1;

    chk("rst_write", 32'(write_to_rd), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_rd_value", rd_value, 32'd0);

    rs1 = 5'd5;
    drive(1, 5'd5, 32'hAAAA0001, 0, 5'd0, 32'd0);
    chk("t1_write", 32'(write_to_rd), 32'd1);
    chk("t1_rd", 32'(rd), 32'd5);
    chk("t1_value", rd_value, 32'hAAAA0001);
    chk("t1_pend", 32'(rs1_pending), 32'd1);
    idle(1);
    chk("t1_pend_drop", 32'(rs1_pending), 32'd0);
    chk("t1_idle", 32'(write_to_rd), 32'd0);

    drive(1, 5'd3, 32'h11, 1, 5'd4, 32'h22);
    chk("t2_rd_a", 32'(rd), 32'd3);
    chk("t2_val_a", rd_value, 32'h11);
    idle(1);
    chk("t2_rd_b", 32'(rd), 32'd4);
    chk("t2_val_b", rd_value, 32'h22);
    idle(1);
    chk("t2_empty", 32'(write_to_rd), 32'd0);

    rs1 = 5'd0;
    rs2 = 5'd7;
    drive(1, 5'd0, 32'h99, 1, 5'd7, 32'h77);
    chk("t3_rd", 32'(rd), 32'd7);
    chk("t3_value", rd_value, 32'h77);
    chk("t3_rs0", 32'(rs1_pending), 32'd0);
    chk("t3_rs7", 32'(rs2_pending), 32'd1);
    idle(1);
    chk("t3_one_only", 32'(write_to_rd), 32'd0);

    drive(1, 5'd10, 32'hA0, 1, 5'd11, 32'hB0);
    drive(1, 5'd12, 32'hC0, 1, 5'd13, 32'hD0);
    chk("t4_ready_low", 32'(ready), 32'd0);
    chk("t4_head", 32'(rd), 32'd11);
    drive(0, 5'd0, 32'd0, 1, 5'd14, 32'hE0);
    chk("t4_overflow", 32'(overflow), 32'd1);
    chk("t4_drain_a", 32'(rd), 32'd12);
    chk("t4_drain_a_v", rd_value, 32'hC0);
    idle(1);
    chk("t4_drain_b", 32'(rd), 32'd13);
    chk("t4_drain_b_v", rd_value, 32'hD0);
    idle(1);
    chk("t4_dropped", 32'(write_to_rd), 32'd0);
    chk("t4_sticky", 32'(overflow), 32'd1);

    rs2 = 5'd9;
    drive(1, 5'd9, 32'h1, 1, 5'd9, 32'h2);
    chk("t5_pend_a", 32'(rs2_pending), 32'd1);
    chk("t5_val_a", rd_value, 32'h1);
`ifdef WB_BYPASS_EN
    chk("t5_fwd_a", rs2_fwd_value, 32'h2);
`endif
    idle(1);
    chk("t5_pend_b", 32'(rs2_pending), 32'd1);
    chk("t5_val_b", rd_value, 32'h2);
    idle(1);
    chk("t5_pend_clr", 32'(rs2_pending), 32'd0);

    rs1 = 5'd21;
    rs2 = 5'd22;
    drive(1, 5'd20, 32'h20, 1, 5'd21, 32'h21);
    drive(1, 5'd22, 32'h22, 1, 5'd23, 32'h23);
    chk("t6_full", 32'(ready), 32'd0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("t6_write", 32'(write_to_rd), 32'd0);
    chk("t6_pend1", 32'(rs1_pending), 32'd0);
    chk("t6_pend2", 32'(rs2_pending), 32'd0);
    chk("t6_ready", 32'(ready), 32'd1);
    chk("t6_overflow", 32'(overflow), 32'd0);

    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 199) == 0);
      load_valid = ($urandom_range(0, 2) == 0);
      load_rd    = 5'($urandom_range(0, 7));
      load_value = $urandom;
      alu_valid  = ($urandom_range(0, 2) == 0);
      alu_rd     = 5'($urandom_range(0, 7));
      alu_value  = $urandom;
      rs1        = 5'($urandom_range(0, 7));
      rs2        = 5'($urandom_range(0, 7));
      idle(1);
    end
    reset      = 1'b0;
    load_valid = 1'b0;
    alu_valid  = 1'b0;
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
